// File: rtl/fifo_frame_reader_pkg.sv
// Shared definitions for the digitizer FIFO read-side sequencer.
// Header layout, default marker, FSM encoding and buffer entry.
package digitizer_fifo_pkg;

   localparam int HDR_SYNC_MSB = 31;
   localparam int HDR_SYNC_LSB = 24;
   localparam int HDR_SEQ_MSB  = 23;
   localparam int HDR_SEQ_LSB  = 16;
   localparam int HDR_LEN_MSB  = 15;
   localparam int HDR_LEN_LSB  = 0;

   localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2
   } state_e;

   typedef struct packed {
      logic        last;
      logic [31:0] data;
   } buf_entry_t;

   function automatic logic [31:0] make_header(
      input logic [7:0]  sync,
      input logic [7:0]  seq,
      input logic [15:0] len
   );
      logic [31:0] h;
      h = '0;
      h[HDR_SYNC_MSB:HDR_SYNC_LSB] = sync;
      h[HDR_SEQ_MSB:HDR_SEQ_LSB]   = seq;
      h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
      return h;
   endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Small in-order output buffer with two ordered push ports.
// Port a is written ahead of port b when both push together.
module stream_skid_buf #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 33,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_a,
   input  logic [WIDTH-1:0] data_a,
   input  logic             push_b,
   input  logic [WIDTH-1:0] data_b,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             head_valid,
   output logic [CW-1:0]    occupancy
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    occ;
   logic             pop_eff;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   assign pop_eff    = pop && (occ != '0);
   assign head       = mem[rd_ptr];
   assign head_valid = (occ != '0);
   assign occupancy  = occ;

   // Storage, pointers and occupancy; a lands before b in order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem    <= '{default: '0};
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push_a) begin
            mem[wr_ptr] <= data_a;
         end
         if (push_b) begin
            mem[push_a ? nxt(wr_ptr) : wr_ptr] <= data_b;
         end
         if (push_a && push_b) begin
            wr_ptr <= nxt(nxt(wr_ptr));
         end else if (push_a || push_b) begin
            wr_ptr <= nxt(wr_ptr);
         end
         if (pop_eff) begin
            rd_ptr <= nxt(rd_ptr);
         end
         occ <= occ + CW'(push_a) + CW'(push_b) - CW'(pop_eff);
      end
   end

endmodule

// File: rtl/fifo_frame_reader.sv
// Read-side frame sequencer for a non-FWFT COREFIFO.
// Emits header + FRAME_LEN words per frame on a valid/ready stream.
module fifo_frame_reader
   import digitizer_fifo_pkg::*;
#(
   parameter int         DATA_WIDTH = 32,
   parameter int         FRAME_LEN  = 256,
   parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE,
   parameter int         RD_LATENCY = 1
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  ENABLE,
   input  logic                  FIFO_EMPTY,
   output logic                  FIFO_RE,
   input  logic [DATA_WIDTH-1:0] FIFO_Q,
   output logic [DATA_WIDTH-1:0] M_DATA,
   output logic                  M_VALID,
   output logic                  M_LAST,
   input  logic                  M_READY,
   output logic                  BUSY,
   output logic [15:0]           FRAME_CNT
);

   localparam int BUF_DEPTH = RD_LATENCY + 1;
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int SW = CW + 1;
   localparam int IW = $clog2(RD_LATENCY + 1);

   localparam logic [1:0] IDLE    = ST_IDLE;
   localparam logic [1:0] HEADER  = ST_HEADER;
   localparam logic [1:0] PAYLOAD = ST_PAYLOAD;

   localparam logic [15:0] LEN    = 16'(FRAME_LEN);
   localparam logic [15:0] LEN_M1 = 16'(FRAME_LEN - 1);

   logic [1:0]            state;
   logic [7:0]            seq;
   logic [15:0]           req_cnt;
   logic [RD_LATENCY-1:0] sr_vld;
   logic [RD_LATENCY-1:0] sr_last;
   logic [IW-1:0]         inflight;
   logic [CW-1:0]         occ;
   logic [DATA_WIDTH:0]   head;
   logic [DATA_WIDTH:0]   hdr_entry;
   logic [DATA_WIDTH:0]   cap_entry;
   logic                  head_valid;
   logic                  pop;
   logic                  cap;
   logic                  room;
   logic                  hdr_push;
   logic                  rd_issue;
   logic                  rd_last;
   logic [SW-1:0]         used;
   logic [SW-1:0]         limit;

   // Slots still unclaimed after counting returning reads.
   assign pop   = head_valid && M_READY;
   assign cap   = sr_vld[RD_LATENCY-1];
   assign used  = SW'(occ) + SW'(inflight);
   assign limit = SW'(BUF_DEPTH) + SW'(pop);
   assign room  = (used < limit);

   assign hdr_push = (state == HEADER) && room;
   assign rd_last  = (req_cnt == LEN_M1);
   assign rd_issue = RESET_N && (state == PAYLOAD) &&
                     !FIFO_EMPTY && (req_cnt < LEN) && room;

   assign hdr_entry = {1'b0,
                       DATA_WIDTH'(make_header(SYNC_BYTE, seq, LEN))};
   assign cap_entry = {sr_last[RD_LATENCY-1], FIFO_Q};

   assign FIFO_RE = rd_issue;
   assign M_VALID = head_valid;
   assign M_DATA  = head[DATA_WIDTH-1:0];
   assign M_LAST  = head_valid && head[DATA_WIDTH];
   assign BUSY    = (state != IDLE) || (occ != '0) ||
                    (inflight != '0);

   stream_skid_buf #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (DATA_WIDTH + 1)
   ) u_buf (
      .clk        (CLK),
      .rst_n      (RESET_N),
      .push_a     (cap),
      .data_a     (cap_entry),
      .push_b     (hdr_push),
      .data_b     (hdr_entry),
      .pop        (pop),
      .head       (head),
      .head_valid (head_valid),
      .occupancy  (occ)
   );

   // Frame sequencing: idle, header slot, then payload reads.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state   <= IDLE;
         seq     <= '0;
         req_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (ENABLE) begin
                  state <= HEADER;
               end
            end
            HEADER: begin
               if (hdr_push) begin
                  state   <= PAYLOAD;
                  seq     <= seq + 8'd1;
                  req_cnt <= '0;
               end
            end
            PAYLOAD: begin
               if (rd_issue) begin
                  req_cnt <= req_cnt + 16'd1;
                  if (rd_last) begin
                     state <= ENABLE ? HEADER : IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tags for reads whose data is still on its way from the FIFO.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         sr_vld   <= '0;
         sr_last  <= '0;
         inflight <= '0;
      end else begin
         sr_vld[0]  <= rd_issue;
         sr_last[0] <= rd_issue && rd_last;
         for (int i = 1; i < RD_LATENCY; i++) begin
            sr_vld[i]  <= sr_vld[i-1];
            sr_last[i] <= sr_last[i-1];
         end
         inflight <= inflight + IW'(rd_issue) - IW'(cap);
      end
   end

   // Completed-frame counter, bumped on the accepted last beat.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         FRAME_CNT <= '0;
      end else if (pop && head[DATA_WIDTH]) begin
         FRAME_CNT <= FRAME_CNT + 16'd1;
      end
   end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Self-checking bench for fifo_frame_reader.
// Four instances (FRAME_LEN 4/16/8/1) share one FIFO model.
module tb_fifo_frame_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        fifo_empty;
   logic        m_ready;
   logic [31:0] fifo_q;
   logic [1:0]  sel;

   logic        re_a   [4];
   logic        val_a  [4];
   logic        last_a [4];
   logic        busy_a [4];
   logic [31:0] data_a [4];
   logic [15:0] cnt_a  [4];

   logic        fre, mvalid, mlast, mbusy;
   logic [31:0] mdata;
   logic [15:0] mcnt;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int FL = (g == 0) ? 4 : (g == 1) ? 16 :
                          (g == 2) ? 8 : 1;
      logic dut_rst;
      logic dut_en;
      assign dut_rst = rst_n && (sel == 2'(g));
      assign dut_en  = enable && (sel == 2'(g));
      fifo_frame_reader #(.FRAME_LEN(FL)) u_dut (
         .CLK        (clk),
         .RESET_N    (dut_rst),
         .ENABLE     (dut_en),
         .FIFO_EMPTY (fifo_empty),
         .FIFO_RE    (re_a[g]),
         .FIFO_Q     (fifo_q),
         .M_DATA     (data_a[g]),
         .M_VALID    (val_a[g]),
         .M_LAST     (last_a[g]),
         .M_READY    (m_ready),
         .BUSY       (busy_a[g]),
         .FRAME_CNT  (cnt_a[g])
      );
   end

   assign fre    = re_a[sel];
   assign mvalid = val_a[sel];
   assign mlast  = last_a[sel];
   assign mbusy  = busy_a[sel];
   assign mdata  = data_a[sel];
   assign mcnt   = cnt_a[sel];

   logic [31:0] fq [$];
   logic [32:0] got [$];
   logic [32:0] exp_q [$];
   int          got_cyc [$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          issued = 0;

   typedef struct {
      logic        en;
      logic        v;
      logic [31:0] d;
      logic        l;
      logic        re;
      logic        busy;
   } vec_t;
   vec_t tv [9];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   // One clock: FIFO model pops after the edge (1-cycle latency).
   task automatic step(output bit rd);
      #5;
      rd = fre;
      @(posedge clk);
      #1;
      cyc++;
      if (rd) begin
         issued++;
         if (fq.size() != 0) fifo_q = fq.pop_front();
      end
      fifo_empty = (fq.size() == 0);
   endtask

   task automatic tick();
      bit r;
      step(r);
   endtask

   task automatic push(input logic [31:0] v);
      fq.push_back(v);
      fifo_empty = 1'b0;
   endtask

   function automatic logic [32:0] hdr(input int fl, input int s);
      logic [7:0]  sb;
      logic [15:0] lb;
      sb = 8'(s);
      lb = 16'(fl);
      return {1'b0, 8'hA5, sb, lb};
   endfunction

   // Expected stream built from frame rules: header, then fl words.
   task automatic add_frames(input int fl, input int nfr,
                             input logic [31:0] w [$]);
      int k = 0;
      for (int f = 0; f < nfr; f++) begin
         exp_q.push_back(hdr(fl, f));
         for (int j = 0; j < fl; j++) begin
            exp_q.push_back({j == fl - 1, w[k]});
            k++;
         end
      end
   endtask

   task automatic cmp_all(input string nm);
      for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
         chk($sformatf("%s_beat%0d", nm, k), 64'(got[k]),
             64'(exp_q[k]));
      end
   endtask

   task automatic run(input int n, input int want, input bit rnd,
                      input int fl, input bit room_chk);
      bit          stalled = 0;
      bit          rd;
      logic [32:0] prev = '0;
      int          pay = 0;
      for (int i = 0; i < n && got.size() < want; i++) begin
         m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (stalled) begin
            chk("stall_hold", 64'({mvalid, mlast, mdata}),
                64'({1'b1, prev}));
         end
         stalled = mvalid && !m_ready;
         prev = {mlast, mdata};
         if (mvalid && m_ready) begin
            if ((got.size() % (fl + 1)) != 0) pay++;
            got.push_back({mlast, mdata});
            got_cyc.push_back(cyc);
         end
         step(rd);
         if (room_chk && rd) begin
            chk("re_room", 64'(issued - pay <= 2), 64'd1);
         end
      end
      chk("beat_count", 64'(got.size()), 64'(want));
   endtask

   task automatic do_reset(input logic [1:0] s);
      rst_n   = 1'b0;
      enable  = 1'b0;
      m_ready = 1'b1;
      sel     = s;
      tick();
      tick();
      rst_n = 1'b1;
      fq.delete();
      fifo_empty = 1'b1;
      got.delete();
      got_cyc.delete();
      exp_q.delete();
      issued = 0;
   endtask

   task automatic pulse_enable();
      enable = 1'b1;
      tick();
      enable = 1'b0;
   endtask

   initial begin
      logic [31:0] ws [$];
      bit any_v;
      bit any_re;
      bit found;

      rst_n = 1'b0;
      enable = 1'b0;
      m_ready = 1'b0;
      fifo_q = '0;
      fifo_empty = 1'b1;
      sel = 2'd0;
      do_reset(2'd0);
      #1;
      chk("rst_re", 64'(fre), 0);
      chk("rst_valid", 64'(mvalid), 0);
      chk("rst_last", 64'(mlast), 0);
      chk("rst_data", 64'(mdata), 0);
      chk("rst_busy", 64'(mbusy), 0);
      chk("rst_cnt", 64'(mcnt), 0);

      tv[0] = '{1, 0, 32'h0,        0, 0, 0};
      tv[1] = '{0, 0, 32'h0,        0, 0, 1};
      tv[2] = '{0, 1, 32'hA5000004, 0, 1, 1};
      tv[3] = '{0, 0, 32'h0,        0, 1, 1};
      tv[4] = '{0, 1, 32'd1,        0, 1, 1};
      tv[5] = '{0, 1, 32'd2,        0, 1, 1};
      tv[6] = '{0, 1, 32'd3,        0, 0, 1};
      tv[7] = '{0, 1, 32'd4,        1, 0, 1};
      tv[8] = '{0, 0, 32'h0,        0, 0, 0};
      for (int i = 1; i <= 4; i++) push(32'(i));
      for (int i = 0; i < 9; i++) begin
         enable = tv[i].en;
         m_ready = 1'b1;
         #1;
         chk($sformatf("basic_valid_c%0d", i), 64'(mvalid),
             64'(tv[i].v));
         chk($sformatf("basic_re_c%0d", i), 64'(fre), 64'(tv[i].re));
         chk($sformatf("basic_busy_c%0d", i), 64'(mbusy),
             64'(tv[i].busy));
         if (tv[i].v) begin
            chk($sformatf("basic_data_c%0d", i), 64'(mdata),
                64'(tv[i].d));
            chk($sformatf("basic_last_c%0d", i), 64'(mlast),
                64'(tv[i].l));
         end
         tick();
      end
      enable = 1'b0;
      any_re = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         any_re |= fre;
         tick();
      end
      chk("basic_no_more_re", 64'(any_re), 0);
      chk("basic_frame_cnt", 64'(mcnt), 1);
      chk("basic_busy_end", 64'(mbusy), 0);

      do_reset(2'd0);
      push(32'h10);
      push(32'h11);
      pulse_enable();
      run(40, 3, 0, 4, 0);
      any_v = 0;
      any_re = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         any_v |= mvalid;
         any_re |= fre;
         tick();
      end
      chk("empty_valid", 64'(any_v), 0);
      chk("empty_re", 64'(any_re), 0);
      chk("empty_busy", 64'(mbusy), 1);
      push(32'h12);
      push(32'h13);
      run(40, 5, 0, 4, 0);
      ws = '{32'h10, 32'h11, 32'h12, 32'h13};
      add_frames(4, 1, ws);
      cmp_all("empty");
      #1;
      chk("empty_frame_cnt", 64'(mcnt), 1);

      do_reset(2'd1);
      ws.delete();
      for (int i = 0; i < 64; i++) begin
         ws.push_back($urandom);
         push(ws[i]);
      end
      enable = 1'b1;
      add_frames(16, 4, ws);
      run(3000, 68, 1, 16, 1);
      enable = 1'b0;
      cmp_all("rand");

      do_reset(2'd2);
      ws.delete();
      for (int i = 0; i < 24; i++) begin
         ws.push_back(32'h800 + 32'(i));
         push(ws[i]);
      end
      enable = 1'b1;
      add_frames(8, 3, ws);
      run(200, 27, 0, 8, 0);
      enable = 1'b0;
      cmp_all("cont");
      if (got_cyc.size() == 27) begin
         chk("cont_span", 64'(got_cyc[26] - got_cyc[1]), 64'd25);
      end

      do_reset(2'd0);
      for (int i = 1; i <= 4; i++) push(32'h20 + 32'(i));
      pulse_enable();
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         m_ready = 1'b1;
         #1;
         if (mvalid && mdata == 32'h23) found = 1;
         else tick();
      end
      chk("rstmid_reached_w3", 64'(found), 1);
      rst_n = 1'b0;
      tick();
      chk("rstmid_re", 64'(fre), 0);
      chk("rstmid_valid", 64'(mvalid), 0);
      chk("rstmid_last", 64'(mlast), 0);
      chk("rstmid_data", 64'(mdata), 0);
      chk("rstmid_busy", 64'(mbusy), 0);
      chk("rstmid_cnt", 64'(mcnt), 0);
      rst_n = 1'b1;
      any_v = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         any_v |= mvalid;
         tick();
      end
      chk("rstmid_no_late", 64'(any_v), 0);
      got.delete();
      for (int i = 1; i <= 4; i++) push(32'h30 + 32'(i));
      pulse_enable();
      run(40, 5, 0, 4, 0);
      if (got.size() == 5) begin
         chk("rstmid_hdr", 64'(got[0]), 64'(hdr(4, 0)));
         chk("rstmid_w1", 64'(got[1]), 64'h31);
         chk("rstmid_w4", 64'(got[4]), 64'h1_0000_0034);
      end

      do_reset(2'd3);
      ws.delete();
      for (int i = 0; i < 257; i++) begin
         ws.push_back(32'h1000 + 32'(i));
         push(ws[i]);
      end
      enable = 1'b1;
      add_frames(1, 256, ws);
      exp_q.push_back(hdr(1, 256));
      run(2000, 512, 0, 1, 0);
      chk("wrap_frame_cnt", 64'(mcnt), 64'd256);
      run(20, 513, 0, 1, 0);
      enable = 1'b0;
      cmp_all("wrap");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
